mc8051_cycle_seq: RTL and testbench

- Instruction-cycle sequencer for the mc8051 core; it is the producer/consumer opposite the op decoder.
- Fetches the opcode and holds it in the instruction buffer. Drives the ci_stage counter and the S1/S2/S3 done ticks into the decoder.
- Consumes the returned microcode word to run the operand-read, execute and write-back stages through a req/ack memory handshake.
- Chains multi-stage instructions: when the microcode continue bit is set, it re-runs S2..S5 with ci_stage incremented, without refetching the opcode.

---
 rtl/mc8051_cycle_seq_pkg.sv | 40 ++++
 rtl/mc8051_cycle_seq_if.sv | 18 +
 rtl/mc8051_mem_hs.sv | 57 +++++
 rtl/mc8051_cycle_seq.sv | 145 ++++++++++++++
 tb/tb_mc8051_cycle_seq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc8051_cycle_seq_pkg.sv
// rtl/mc8051_cycle_seq_pkg.sv - shared constants and types for the instruction-cycle sequencer
package mc8051_cycle_seq_pkg;

    localparam int MCODE_WIDTH = 16;

    // Microcode field placement; CONT is always the MSB of the word.
    localparam int S2_PCINC_BIT = 0;
    localparam int S2_MODE_LSB  = 1;
    localparam int S3_PCINC_BIT = 3;
    localparam int S3_MODE_LSB  = 4;
    localparam int S5_MODE_LSB  = 6;
    localparam int MODE_W       = 2;

    localparam logic [MODE_W-1:0] DISCARD_MODE    = 2'b00;
    localparam logic [MODE_W-1:0] WR_DISCARD_MODE = 2'b00;

    localparam logic [2:0] MEM_STAGE_S1 = 3'd1;
    localparam logic [2:0] MEM_STAGE_S2 = 3'd2;
    localparam logic [2:0] MEM_STAGE_S3 = 3'd3;
    localparam logic [2:0] MEM_STAGE_S5 = 3'd5;

    typedef enum logic [2:0] {
        S1_FETCH = 3'd0,
        S2_RD    = 3'd1,
        S3_RD    = 3'd2,
        S4_EXEC  = 3'd3,
        S5_WB    = 3'd4
    } seq_state_e;

    function automatic logic [2:0] stage_code(input seq_state_e s);
        case (s)
            S1_FETCH: return MEM_STAGE_S1;
            S2_RD:    return MEM_STAGE_S2;
            S3_RD:    return MEM_STAGE_S3;
            S5_WB:    return MEM_STAGE_S5;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mc8051_cycle_seq_if.sv
// rtl/mc8051_cycle_seq_if.sv - req/ack memory handshake between sequencer and memory
interface mc8051_cycle_seq_if;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] mem_stage;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_stage,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_stage,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mc8051_mem_hs.sv
// rtl/mc8051_mem_hs.sv - shared req/ack holder with per-stage read data latches
module mc8051_mem_hs
    import mc8051_cycle_seq_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_en,
    input  logic                      i_we,
    input  logic [2:0]                i_stage,
    mc8051_cycle_seq_if.master        mem,
    output logic                      o_done,
    output logic [7:0]                o_instr_buffer,
    output logic [7:0]                o_s2_buf,
    output logic [7:0]                o_s3_buf
);

    logic [7:0] instr_buffer_q, instr_buffer_d;
    logic [7:0] s2_buf_q, s2_buf_d;
    logic [7:0] s3_buf_q, s3_buf_d;

    // An ack only counts while a request is up and reset is not being applied.
    assign o_done = i_req_en & mem.mem_ack & ~i_rst;

    always_comb begin
        mem.mem_req    = i_req_en;
        mem.mem_we     = i_req_en & i_we;
        mem.mem_stage  = i_req_en ? i_stage : 3'd0;
        instr_buffer_d = instr_buffer_q;
        s2_buf_d       = s2_buf_q;
        s3_buf_d       = s3_buf_q;
        if (o_done && !i_we) begin
            case (i_stage)
                MEM_STAGE_S1: instr_buffer_d = mem.mem_rdata;
                MEM_STAGE_S2: s2_buf_d       = mem.mem_rdata;
                MEM_STAGE_S3: s3_buf_d       = mem.mem_rdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            instr_buffer_q <= 8'h00;
            s2_buf_q       <= 8'h00;
            s3_buf_q       <= 8'h00;
        end else begin
            instr_buffer_q <= instr_buffer_d;
            s2_buf_q       <= s2_buf_d;
            s3_buf_q       <= s3_buf_d;
        end
    end

    assign o_instr_buffer = instr_buffer_q;
    assign o_s2_buf       = s2_buf_q;
    assign o_s3_buf       = s3_buf_q;

endmodule

// File: rtl/mc8051_cycle_seq.sv
// rtl/mc8051_cycle_seq.sv - S1..S5 instruction-cycle sequencer facing the op decoder
module mc8051_cycle_seq
    import mc8051_cycle_seq_pkg::*;
#(
    parameter int MCODE_W  = MCODE_WIDTH,
    parameter bit STALL_EN = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [MCODE_W-1:0] i_mc_b,
    mc8051_cycle_seq_if.master mem,
    output logic [7:0]         o_instr_buffer,
    output logic [1:0]         o_ci_stage,
    output logic               o_s1_done_tick,
    output logic               o_s2_done_tick,
    output logic               o_s3_done_tick,
    output logic               o_exec_tick,
    output logic               o_s5_done_tick,
    output logic [7:0]         o_s2_buf,
    output logic [7:0]         o_s3_buf,
    output logic               o_pc_inc,
    input  logic               i_stall,
    output logic               o_seq_err
);

    seq_state_e  state_q, state_d;
    logic [1:0]  ci_stage_q, ci_stage_d;
    logic        seq_err_q, seq_err_d;
    logic        active_q, active_d;

    logic              cont, s2_pcinc, s3_pcinc, mc_unused;
    logic [MODE_W-1:0] s2_mode, s3_mode, s5_mode;
    logic              need_req, req_we, req_en, pc_bit, hs_done, stage_done;
    logic [2:0]        stage_sel;

    assign cont      = i_mc_b[MCODE_W-1];
    assign s2_pcinc  = i_mc_b[S2_PCINC_BIT];
    assign s3_pcinc  = i_mc_b[S3_PCINC_BIT];
    assign s2_mode   = i_mc_b[S2_MODE_LSB +: MODE_W];
    assign s3_mode   = i_mc_b[S3_MODE_LSB +: MODE_W];
    assign s5_mode   = i_mc_b[S5_MODE_LSB +: MODE_W];
    assign mc_unused = ^i_mc_b;
    assign stage_sel = stage_code(state_q);

    always_comb begin
        need_req = 1'b0;
        req_we   = 1'b0;
        pc_bit   = 1'b0;
        case (state_q)
            S1_FETCH: begin
                need_req = 1'b1;
                pc_bit   = 1'b1;
            end
            S2_RD: begin
                need_req = (s2_mode != DISCARD_MODE);
                pc_bit   = s2_pcinc;
            end
            S3_RD: begin
                need_req = (s3_mode != DISCARD_MODE);
                pc_bit   = s3_pcinc;
            end
            S5_WB: begin
                need_req = (s5_mode != WR_DISCARD_MODE);
                req_we   = 1'b1;
            end
            default: ;
        endcase
        // active_q keeps the request low in the cycle right after reset.
        req_en = active_q & need_req;
    end

    mc8051_mem_hs u_mem_hs (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_en       (req_en),
        .i_we           (req_we),
        .i_stage        (stage_sel),
        .mem            (mem),
        .o_done         (hs_done),
        .o_instr_buffer (o_instr_buffer),
        .o_s2_buf       (o_s2_buf),
        .o_s3_buf       (o_s3_buf)
    );

    always_comb begin
        if (!active_q || i_rst)        stage_done = 1'b0;
        else if (state_q == S4_EXEC)   stage_done = !(STALL_EN && i_stall);
        else if (need_req)             stage_done = hs_done;
        else                           stage_done = 1'b1;

        state_d    = state_q;
        ci_stage_d = ci_stage_q;
        seq_err_d  = seq_err_q;
        active_d   = 1'b1;
        if (stage_done) begin
            case (state_q)
                S1_FETCH: begin
                    state_d    = S2_RD;
                    ci_stage_d = 2'd0;
                end
                S2_RD:   state_d = S3_RD;
                S3_RD:   state_d = S4_EXEC;
                S4_EXEC: state_d = S5_WB;
                S5_WB: begin
                    if (!cont) begin
                        state_d = S1_FETCH;
                    end else if (ci_stage_q != 2'd3) begin
                        ci_stage_d = ci_stage_q + 2'd1;
                        state_d    = S2_RD;
                    end else begin
                        // Chain ran past the last microcode stage: flag it and refetch.
                        seq_err_d  = 1'b1;
                        ci_stage_d = 2'd0;
                        state_d    = S1_FETCH;
                    end
                end
                default: state_d = S1_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S1_FETCH;
            ci_stage_q <= 2'd0;
            seq_err_q  <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ci_stage_q <= ci_stage_d;
            seq_err_q  <= seq_err_d;
            active_q   <= active_d;
        end
    end

    assign o_s1_done_tick = stage_done && (state_q == S1_FETCH);
    assign o_s2_done_tick = stage_done && (state_q == S2_RD);
    assign o_s3_done_tick = stage_done && (state_q == S3_RD);
    assign o_exec_tick    = stage_done && (state_q == S4_EXEC);
    assign o_s5_done_tick = stage_done && (state_q == S5_WB);
    assign o_pc_inc       = stage_done && need_req && pc_bit;
    assign o_ci_stage     = ci_stage_q;
    assign o_seq_err      = seq_err_q;

endmodule

// File: tb/tb_mc8051_cycle_seq.sv
// tb/tb_mc8051_cycle_seq.sv - directed self-checking bench for mc8051_cycle_seq
module tb_mc8051_cycle_seq;
    import mc8051_cycle_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [MCODE_WIDTH-1:0] mc_b;
    logic [7:0]             instr_buffer, s2_buf, s3_buf;
    logic [1:0]             ci_stage;
    logic                   s1_tick, s2_tick, s3_tick, ex_tick, s5_tick;
    logic                   pc_inc, stall, seq_err;

    mc8051_cycle_seq_if mem_if ();

    mc8051_cycle_seq #(.MCODE_W(MCODE_WIDTH), .STALL_EN(1'b1)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mc_b         (mc_b),
        .mem            (mem_if),
        .o_instr_buffer (instr_buffer),
        .o_ci_stage     (ci_stage),
        .o_s1_done_tick (s1_tick),
        .o_s2_done_tick (s2_tick),
        .o_s3_done_tick (s3_tick),
        .o_exec_tick    (ex_tick),
        .o_s5_done_tick (s5_tick),
        .o_s2_buf       (s2_buf),
        .o_s3_buf       (s3_buf),
        .o_pc_inc       (pc_inc),
        .i_stall        (stall),
        .o_seq_err      (seq_err)
    );

    // Decoder stand-in: 74 = MOV A,#imm, 88 = MOV dir,Rn (2 stages), 85 = MOV dir,dir, FF = forced CONT
    always_comb begin
        case (instr_buffer)
            8'h74:   mc_b = 16'h0003;
            8'h88:   mc_b = (ci_stage == 2'd0) ? 16'h8003 : 16'h0040;
            8'h85:   mc_b = 16'h005B;
            8'hFF:   mc_b = 16'h8000;
            default: mc_b = 16'h0000;
        endcase
    end

    logic [7:0] code_q[$];
    int  wait_s1 = 0, wait_oth = 0, waited = 0, stall_budget = 0;
    bit  auto_mode = 1'b1;
    bit  man_ack = 1'b0;
    logic [7:0] man_rdata = 8'h00;

    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 8'hEE;
        stall            = 1'b0;
        forever begin
            @(negedge clk);
            stall = (stall_budget > 0);
            if (stall_budget > 0) stall_budget--;
            if (!auto_mode) begin
                mem_if.mem_ack   = man_ack;
                mem_if.mem_rdata = man_rdata;
            end else begin
                if (mem_if.mem_ack) begin
                    mem_if.mem_ack   = 1'b0;
                    mem_if.mem_rdata = 8'hEE;
                    waited           = 0;
                end
                if (mem_if.mem_req) begin
                    if (waited >= ((mem_if.mem_stage == 3'd1) ? wait_s1 : wait_oth)) begin
                        mem_if.mem_ack = 1'b1;
                        if (!mem_if.mem_we && code_q.size() > 0)
                            mem_if.mem_rdata = code_q.pop_front();
                    end else begin
                        waited++;
                    end
                end else begin
                    waited = 0;
                end
            end
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int n_cyc, cnt_s1, cnt_ex, cnt_pc, cnt_req, cnt_req1, cnt_req2, cnt_we;
    int t_s1, t_s2, t_s3, t_ex, t_s5, first_ci, first_err;

    task automatic run_instr(input int max_cyc);
        bit done = 1'b0;
        n_cyc = 0; cnt_s1 = 0; cnt_ex = 0; cnt_pc = 0; cnt_req = 0;
        cnt_req1 = 0; cnt_req2 = 0; cnt_we = 0;
        t_s1 = 0; t_s2 = 0; t_s3 = 0; t_ex = 0; t_s5 = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk); #2;
            if (c == 1) begin
                first_ci  = int'(ci_stage);
                first_err = int'(seq_err);
            end
            n_cyc = c;
            if (s1_tick) begin cnt_s1++; t_s1 = c; end
            if (s2_tick) t_s2 = c;
            if (s3_tick) t_s3 = c;
            if (ex_tick) begin cnt_ex++; t_ex = c; end
            if (pc_inc) cnt_pc++;
            if (mem_if.mem_req) begin
                cnt_req++;
                if (mem_if.mem_stage == 3'd1) cnt_req1++;
                if (mem_if.mem_stage == 3'd2) cnt_req2++;
                if (mem_if.mem_we) cnt_we++;
            end
            if (s5_tick) begin
                t_s5 = c;
                done = 1'b1;
                break;
            end
        end
        chk("instr_completes", 32'(done), 1);
    endtask

    initial begin
        rst = 1'b1;
        code_q = '{8'h00, 8'h74, 8'h12, 8'h88, 8'h34, 8'h85, 8'h56, 8'h78,
                   8'h74, 8'h9A, 8'h00, 8'hFF, 8'h00};
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req", 32'(mem_if.mem_req), 0);
        chk("rst_stage", 32'(mem_if.mem_stage), 0);
        chk("rst_instr", 32'(instr_buffer), 0);
        chk("rst_ci", 32'(ci_stage), 0);
        chk("rst_err", 32'(seq_err), 0);
        chk("rst_s1_tick", 32'(s1_tick), 0);
        chk("rst_pc_inc", 32'(pc_inc), 0);
        rst = 1'b0;

        run_instr(20);
        chk("nop_len", n_cyc, 5);
        chk("nop_t_s1", t_s1, 1);
        chk("nop_t_s2", t_s2, 2);
        chk("nop_t_s3", t_s3, 3);
        chk("nop_t_ex", t_ex, 4);
        chk("nop_t_s5", t_s5, 5);
        chk("nop_req_cycles", cnt_req, 1);
        chk("nop_pc_inc", cnt_pc, 1);
        chk("nop_instr", 32'(instr_buffer), 32'h00);

        run_instr(20);
        chk("mova_len", n_cyc, 5);
        chk("mova_req_cycles", cnt_req, 2);
        chk("mova_s2_req", cnt_req2, 1);
        chk("mova_pc_inc", cnt_pc, 2);
        chk("mova_s3_discard", t_s3, 3);
        chk("mova_s2_buf", 32'(s2_buf), 32'h12);
        chk("mova_instr", 32'(instr_buffer), 32'h74);

        run_instr(20);
        chk("movrn_p0_len", n_cyc, 5);
        chk("movrn_p0_pc_inc", cnt_pc, 2);
        chk("movrn_s2_buf", 32'(s2_buf), 32'h34);
        run_instr(20);
        chk("movrn_p1_ci", first_ci, 1);
        chk("movrn_p1_len", n_cyc, 4);
        chk("movrn_p1_s1_ticks", cnt_s1, 0);
        chk("movrn_p1_s1_req", cnt_req1, 0);
        chk("movrn_p1_write", cnt_we, 1);
        chk("movrn_p1_instr", 32'(instr_buffer), 32'h88);

        run_instr(20);
        chk("movdd_ci_at_s1", first_ci, 1);
        chk("movdd_len", n_cyc, 5);
        chk("movdd_req_cycles", cnt_req, 4);
        chk("movdd_pc_inc", cnt_pc, 3);
        chk("movdd_s2_buf", 32'(s2_buf), 32'h56);
        chk("movdd_s3_buf", 32'(s3_buf), 32'h78);
        chk("movdd_ci_after", 32'(ci_stage), 0);

        wait_s1 = 3;
        run_instr(20);
        wait_s1 = 0;
        chk("dly_len", n_cyc, 8);
        chk("dly_s1_req_cycles", cnt_req1, 4);
        chk("dly_s1_ticks", cnt_s1, 1);
        chk("dly_t_s1", t_s1, 4);
        chk("dly_instr", 32'(instr_buffer), 32'h74);
        chk("dly_s2_buf", 32'(s2_buf), 32'h9A);

        stall_budget = 5;
        run_instr(20);
        chk("stall_len", n_cyc, 7);
        chk("stall_t_ex", t_ex, 6);
        chk("stall_ex_ticks", cnt_ex, 1);

        run_instr(20);
        chk("cont_p0_len", n_cyc, 5);
        chk("cont_p0_req", cnt_req, 1);
        for (int p = 1; p <= 3; p++) begin
            run_instr(20);
            chk("cont_pass_ci", first_ci, p);
            chk("cont_pass_len", n_cyc, 4);
            chk("cont_pass_err", first_err, 0);
        end
        run_instr(20);
        chk("ovf_ci", first_ci, 0);
        chk("ovf_err", first_err, 1);
        chk("ovf_refetch", cnt_req1, 1);
        chk("ovf_err_sticky", 32'(seq_err), 1);

        auto_mode = 1'b0;
        man_ack   = 1'b1;
        man_rdata = 8'h74;
        @(negedge clk); #2;
        chk("rstmid_s1_tick", 32'(s1_tick), 1);
        man_ack = 1'b0;
        @(negedge clk); #2;
        chk("rstmid_s2_req", 32'(mem_if.mem_req), 1);
        chk("rstmid_s2_stage", 32'(mem_if.mem_stage), 2);
        man_ack   = 1'b1;
        man_rdata = 8'hAB;
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rstmid_tick_gated", 32'(s2_tick), 0);
        man_ack = 1'b0;
        @(negedge clk); #2;
        chk("rstmid_req", 32'(mem_if.mem_req), 0);
        chk("rstmid_s2_tick", 32'(s2_tick), 0);
        chk("rstmid_s2_buf", 32'(s2_buf), 0);
        chk("rstmid_instr", 32'(instr_buffer), 0);
        chk("rstmid_err", 32'(seq_err), 0);
        chk("rstmid_pc_inc", 32'(pc_inc), 0);
        rst = 1'b0;
        @(negedge clk); #2;
        chk("rstmid_refetch_req", 32'(mem_if.mem_req), 1);
        chk("rstmid_refetch_stage", 32'(mem_if.mem_stage), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
